// File: rtl/fifo_vec_packer.sv
// fifo_vec_packer: drain-side stage of the activation FIFO.
// Pops scalar elements from a FIFO read port (1-cycle read latency), packs VEC_LEN
// consecutive elements into one vector word and presents it with a valid/ready
// handshake. Vectors are counted per tile and the last vector of each tile is flagged.
// Ports:
//   clk_i          rising-edge clock
//   rstn_i         asynchronous active-low reset
//   en_i           enable new FIFO reads (level)
//   flush_i        synchronous clear: drop partial vector, reset tile count
//   fifo_empty_i   FIFO empty flag
//   fifo_data_i    FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_rd_en_o   FIFO pop request (combinational)
//   out_vec_o      packed vector, element 0 (oldest) in the low WIDTH bits
//   out_valid_o    out_vec_o valid
//   out_ready_i    consumer accepts out_vec_o
//   out_last_o     current vector is the last of its tile (qualified by out_valid_o)
//   tile_done_o    one-cycle pulse after the last vector of a tile is accepted
module fifo_vec_packer #(
    parameter int VEC_LEN   = 8,
    parameter int TILE_VECS = 16,
    parameter int WIDTH     = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     en_i,
    input  logic                     flush_i,
    input  logic                     fifo_empty_i,
    input  logic [WIDTH-1:0]         fifo_data_i,
    output logic                     fifo_rd_en_o,
    output logic [VEC_LEN*WIDTH-1:0] out_vec_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_last_o,
    output logic                     tile_done_o
);
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam int VW = TILE_VECS > 1 ? $clog2(TILE_VECS) : 1;
    localparam logic [1:0] FILL = 2'd0, DRAIN = 2'd1, HOLD = 2'd2;
    localparam logic [CW-1:0] LAST_SLOT = CW'(VEC_LEN - 1);
    localparam logic [CW-1:0] FULL = CW'(VEC_LEN);
    localparam logic [VW-1:0] LAST_VEC = VW'(TILE_VECS - 1);

    logic [1:0]               state_q, state_d;
    logic [CW-1:0]            issued_q, issued_d, cap_q, cap_d;
    logic                     pend_q;
    logic [VW-1:0]            vec_cnt_q, vec_cnt_d;
    logic [VEC_LEN*WIDTH-1:0] vec_q, vec_d;
    logic                     valid_q, valid_d, done_q, done_d;

    // Gated by rstn_i so no pop is requested while reset is held.
    assign fifo_rd_en_o = rstn_i & (state_q == FILL) & en_i & ~fifo_empty_i & ~flush_i & (issued_q < FULL);
    assign out_vec_o    = vec_q;
    assign out_valid_o  = valid_q;
    assign out_last_o   = valid_q & (vec_cnt_q == LAST_VEC);
    assign tile_done_o  = done_q;

    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        cap_d     = cap_q;
        vec_cnt_d = vec_cnt_q;
        vec_d     = vec_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        if (flush_i) begin
            // The element popped last cycle is arriving now; it is dropped by not capturing it.
            state_d   = FILL;
            issued_d  = '0;
            cap_d     = '0;
            vec_cnt_d = '0;
            valid_d   = 1'b0;
        end else begin
            if (fifo_rd_en_o) begin
                issued_d = issued_q + 1'b1;
                if (issued_q == LAST_SLOT) state_d = DRAIN;
            end
            if (pend_q) begin
                for (int i = 0; i < VEC_LEN; i++)
                    if (cap_q == CW'(i)) vec_d[i*WIDTH +: WIDTH] = fifo_data_i;
                cap_d = cap_q + 1'b1;
                if (cap_q == LAST_SLOT) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                end
            end
            if (valid_q && out_ready_i) begin
                state_d   = FILL;
                issued_d  = '0;
                cap_d     = '0;
                valid_d   = 1'b0;
                vec_cnt_d = (vec_cnt_q == LAST_VEC) ? '0 : vec_cnt_q + 1'b1;
                done_d    = vec_cnt_q == LAST_VEC;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= FILL;
            issued_q  <= '0;
            cap_q     <= '0;
            pend_q    <= 1'b0;
            vec_cnt_q <= '0;
            vec_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            issued_q  <= issued_d;
            cap_q     <= cap_d;
            pend_q    <= fifo_rd_en_o;
            vec_cnt_q <= vec_cnt_d;
            vec_q     <= vec_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_fifo_vec_packer.sv
// tb_fifo_vec_packer: directed + randomized bench for fifo_vec_packer against a queue-based model.
module tb_fifo_vec_packer;
    localparam int VL = 8;
    localparam int TV = 2;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            en = 1'b0;
    logic            flush = 1'b0;
    logic            fifo_empty = 1'b1;
    logic [W-1:0]    fifo_data = '0;
    logic            fifo_rd_en;
    logic [VL*W-1:0] out_vec;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_last;
    logic            tile_done;

    fifo_vec_packer #(.VEC_LEN(VL), .TILE_VECS(TV), .WIDTH(W)) dut (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .flush_i(flush),
        .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data), .fifo_rd_en_o(fifo_rd_en),
        .out_vec_o(out_vec), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_last_o(out_last), .tile_done_o(tile_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0]    fq[$];
    logic [W-1:0]    m_buf[$];
    logic [W-1:0]    inflight_val;
    logic [VL*W-1:0] m_vec, last_acc, exp_vec;
    int              m_pop, m_tile, n_acc;
    bit              m_inflight, m_valid, m_done, bubble;
    int              bmode = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pop = 0;
        m_inflight = 0;
        m_buf.delete();
        m_valid = 0;
        m_tile = 0;
        m_done = 0;
        m_vec = '0;
    endtask

    task automatic cycle();
        bit e_rd, d_rd;
        bubble = (bmode == 1) ? ~bubble : (bmode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
        fifo_empty = (fq.size() == 0) || bubble;
        if (!rstn) model_reset();
        #1;
        e_rd = rstn && !m_valid && m_pop < VL && en && !fifo_empty && !flush;
        d_rd = fifo_rd_en;
        chk("rd_en", 64'(d_rd), 64'(e_rd));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_last", 64'(out_last), 64'(m_valid && m_tile == TV - 1));
        chk("tile_done", 64'(tile_done), 64'(m_done));
        if (m_valid || !rstn) chk("out_vec", out_vec, m_vec);
        @(posedge clk);
        if (!rstn || flush) model_reset();
        else begin
            m_done = 0;
            if (m_inflight) begin
                m_buf.push_back(inflight_val);
                m_inflight = 0;
                if (m_buf.size() == VL) begin
                    m_valid = 1;
                    m_vec = '0;
                    for (int i = 0; i < VL; i++) m_vec[i*W +: W] = m_buf[i];
                    m_buf.delete();
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
                m_pop = 0;
                m_done = (m_tile == TV - 1);
                m_tile = (m_tile + 1) % TV;
                n_acc++;
                last_acc = m_vec;
            end
            if (e_rd) begin
                m_pop++;
                m_inflight = 1;
            end
        end
        #1;
        if (d_rd && fq.size() > 0) begin
            inflight_val = fq.pop_front();
            fifo_data = inflight_val;
        end
        @(negedge clk);
    endtask

    task automatic push_seq(input int first, input int count);
        for (int i = 0; i < count; i++) fq.push_back(W'(first + i));
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int k = 0;
        while (n_acc < target && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, 64'(n_acc), 64'(target));
    endtask

    task automatic seq_vec(input int first);
        for (int i = 0; i < VL; i++) exp_vec[i*W +: W] = W'(first + i);
    endtask

    initial begin
        model_reset();
        n_acc = 0;
        last_acc = '0;
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        out_ready = 1'b1;
        push_seq(1, 8);
        run_until("stream_accept", 1, 40);
        seq_vec(1);
        chk("stream_vec", last_acc, exp_vec);

        bmode = 1;
        push_seq(1, 8);
        run_until("bubble_accept", 2, 60);
        seq_vec(1);
        chk("bubble_vec", last_acc, exp_vec);
        bmode = 0;

        out_ready = 1'b0;
        push_seq(40, 16);
        for (int k = 0; k < 40 && !m_valid; k++) cycle();
        for (int i = 0; i < 5; i++) cycle();
        out_ready = 1'b1;
        run_until("bp_accept", 3, 40);
        seq_vec(40);
        chk("bp_vec", last_acc, exp_vec);
        run_until("bp_refill", 4, 40);

        push_seq(1, 24);
        run_until("tile_accept", 7, 120);
        seq_vec(17);
        chk("tile_vec3", last_acc, exp_vec);

        for (int k = 0; k < 10; k++) cycle();
        push_seq(1, 12);
        for (int k = 0; k < 20 && m_pop < 4; k++) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        run_until("flush_accept", 8, 60);
        seq_vec(5);
        chk("flush_vec", last_acc, exp_vec);
        chk("flush_fifo_drained", 64'(fq.size()), 64'(0));

        push_seq(100, 8);
        for (int i = 0; i < 4; i++) cycle();
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) cycle();
        fq.delete();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        bmode = 2;
        for (int c = 0; c < 3000; c++) begin
            en = $urandom_range(0, 9) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 199) == 0;
            if (fq.size() < 20 && $urandom_range(0, 1) == 1) fq.push_back(W'($urandom));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
